spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on sclk/SS/MOSI (legal 2..4).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sclk  input  1  serial clock from SPI master, asynchronous to clk.
REQ-005 SHALL have port SS  input  1  slave select from master, active-low.
REQ-006 SHALL have port MOSI  input  1  serial data from master.
REQ-007 SHALL have port MISO  output  1  serial data to master.
REQ-008 SHALL have port tx_data  input  8  byte to transmit on next frame.
REQ-009 SHALL have port tx_load  input  1  one-cycle strobe capturing tx_data into the TX holding register.
REQ-010 SHALL have port tx_ready  output  1  high when the TX holding register is empty.
REQ-011 SHALL have port rx_data  output  8  last complete received byte.
REQ-012 SHALL have port rx_valid  output  1  high while rx_data holds an unacknowledged byte.
REQ-013 SHALL have port rx_ack  input  1  one-cycle strobe clearing rx_valid.
REQ-014 SHALL have port busy  output  1  high while SS is (synchronized) asserted.
REQ-015 SHALL have port rx_overrun  output  1  sticky overrun flag (see Configuration).

Function
REQ-016 SHALL operate SPI mode 0: MOSI sampled on sclk rising edge, MISO updated on sclk falling edge, MSB first, 8-bit frames.
REQ-017 SHALL pass sclk, SS, MOSI through SYNC_STAGES flops and detect sclk edges from the last two synchronized samples; sclk period SHALL be at least 4 clk periods.
REQ-018 SHALL implement states IDLE (SS high), LOAD (one cycle after SS falls), SHIFT (bits 0..7), with SS rise from any state returning to IDLE next cycle.
REQ-019 In LOAD, SHALL move the TX holding register into the TX shift register, set tx_ready=1, and drive MISO=shift[7] before the first sclk rise; if holding empty, SHALL shift 0x00.
REQ-020 SHALL shift MOSI into RX shift register on each detected rising edge and advance TX shift on each detected falling edge; 3-bit counter wraps 7->0.
REQ-021 On the 8th rising edge of a frame, SHALL copy RX shift into rx_data and set rx_valid on the next clk edge (latency SYNC_STAGES+1 clk from the sclk pin edge).
REQ-022 After a completed frame with SS still low, SHALL reload TX shift from holding register (or 0x00) on the following falling edge and continue with a new frame.
REQ-023 SS rise mid-frame SHALL discard the partial byte: no rx_data update, no rx_valid, counter cleared.
REQ-024 tx_load SHALL be accepted only when tx_ready=1; it clears tx_ready next cycle; tx_load with tx_ready=0 SHALL be ignored.
REQ-025 rx_ack SHALL clear rx_valid next cycle; rx_ack coincident with a byte completion SHALL leave rx_valid=1 with the new byte and SHALL NOT count as overrun.
REQ-026 MISO SHALL be 0 whenever synchronized SS is high; busy SHALL equal inverted synchronized SS.

Reset
REQ-027 rst SHALL asynchronously force: state IDLE, counter 0, shift registers 0x00, holding register empty, MISO=0, tx_ready=1, rx_data=0x00, rx_valid=0, busy=0, rx_overrun=0, synchronizers to SS=1/sclk=0/MOSI=0.
REQ-028 rst asserted mid-frame SHALL abandon the frame; after release, no byte SHALL complete until SS is seen high then low again.

Configuration
REQ-029 With SPI_SLAVE_OVERRUN_EN defined, rx_overrun SHALL set when a byte completes while rx_valid=1 and no coincident rx_ack; it stays set until rst; rx_data is still overwritten.
REQ-030 Without SPI_SLAVE_OVERRUN_EN, rx_overrun SHALL be tied 0 and no overrun logic SHALL be built; all other behaviour identical.

Verification
REQ-031 tx_load with 0xA5, then master frame MOSI=0x0D -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x0D, rx_valid=1; tx_ready=1 after LOAD.
REQ-032 Two back-to-back frames with SS low, MOSI 0x3C then 0xC3, rx_ack after first -> rx_data 0x3C then 0xC3; second MISO frame = 0x00 if no reload.
REQ-033 SS raised after 5 sclk rises of 0xFF -> rx_valid stays 0, rx_data unchanged; next full frame 0x81 -> rx_data=0x81.
REQ-034 Second frame completes without rx_ack, macro defined -> rx_overrun=1, rx_data=second byte; macro undefined -> rx_overrun=0.
REQ-035 rst pulsed after 4 sclk rises -> all outputs at reset values immediately; fresh SS cycle with 0x5A -> rx_data=0x5A.
REQ-036 tx_load 0x11 then tx_load 0x22 with no frame between -> second ignored; next frame MISO shifts 0x11.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 slave with byte-wide TX holding register and RX data register.
// sclk, SS and MOSI are oversampled by clk through SYNC_STAGES flops (2..4).
// Optional feature macro: SPI_SLAVE_OVERRUN_EN builds the sticky rx_overrun
// flag; when undefined, rx_overrun is tied low and no overrun logic exists.
//
// state | meaning
// IDLE  | SS high (or not yet seen high since reset); MISO held at 0
// LOAD  | one cycle after SS falls; TX holding register moves to shifter
// SHIFT | frame in progress; bits counted on synchronized sclk edges
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       SS,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       busy,
  output logic       rx_overrun
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync, flush;
  logic       sclk_prev;
  logic       sclk_s, ss_s, mosi_s;
  logic       sclk_rise, sclk_fall;
  logic       armed;
  logic [2:0] cnt;
  logic [7:0] shift_tx, shift_rx, hold;
  logic       hold_full;
  logic       shift_en, bit_rise, bit_fall, byte_done, reload, take_hold, accept;
  logic [7:0] hold_byte;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;

  // Synchronizer chains; flush marks when the chains hold real pin samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      flush     <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= sclk_s;
    end
  end

  // Arm only after SS has genuinely been seen high since reset, so a frame
  // that was in flight when reset hit can never complete afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) armed <= 1'b0;
    else if (flush[SYNC_STAGES-1] && ss_s) armed <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; SS high always returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (armed && !ss_s) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   state_next = SHIFT;
      default: state_next = IDLE;
    endcase
    if (ss_s) state_next = IDLE;
  end

  assign shift_en  = (state == SHIFT) && !ss_s;
  assign bit_rise  = shift_en && sclk_rise;
  assign bit_fall  = shift_en && sclk_fall;
  assign byte_done = bit_rise && (cnt == 3'd7);
  // A falling edge with the counter at 0 follows a completed byte.
  assign reload    = bit_fall && (cnt == 3'd0);
  assign take_hold = ((state == LOAD) && !ss_s) || reload;
  assign hold_byte = hold_full ? hold : 8'h00;
  assign accept    = tx_load && !hold_full;

  // TX holding register, shifters, bit counter and RX output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= 8'h00;
      hold_full <= 1'b0;
      shift_tx  <= 8'h00;
      shift_rx  <= 8'h00;
      cnt       <= 3'd0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
    end else begin
      if (accept) hold <= tx_data;
      hold_full <= (hold_full && !take_hold) || accept;

      if (take_hold)     shift_tx <= hold_byte;
      else if (bit_fall) shift_tx <= {shift_tx[6:0], 1'b0};

      if (!shift_en)     cnt <= 3'd0;
      else if (bit_rise) cnt <= cnt + 3'd1;

      if (bit_rise)  shift_rx <= {shift_rx[6:0], mosi_s};
      if (byte_done) rx_data  <= {shift_rx[6:0], mosi_s};
      rx_valid <= byte_done || (rx_valid && !rx_ack);
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun_q;

  // Sticky: a byte landed on top of an unacknowledged one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= 1'b0;
    else if (byte_done && rx_valid && !rx_ack) overrun_q <= 1'b1;
  end

  assign rx_overrun = overrun_q;
`else
  assign rx_overrun = 1'b0;
`endif

  assign tx_ready = !hold_full;
  assign busy     = !ss_s;
  assign MISO     = (state == SHIFT) && !ss_s && shift_tx[7];

endmodule
